// File: rtl/axi_lite_slave_regfile.sv
// axi_lite_slave_regfile: AXI-lite responder over a flat register file.
// AW and W are accepted independently; one write and one read may be outstanding.
module axi_lite_slave_regfile #(
    parameter int DATA_WD = 8,
    parameter int ADDR_WD = 8,
    parameter int REG_NUM = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [ADDR_WD-1:0]         awaddr,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_WD-1:0]         wdata,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [ADDR_WD-1:0]         araddr,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_WD-1:0]         rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [REG_NUM*DATA_WD-1:0] reg_out
);
    localparam logic [ADDR_WD:0] LP_REG_NUM = (ADDR_WD+1)'(REG_NUM);

    logic [REG_NUM*DATA_WD-1:0] r_regs;
    logic                       r_aw_hold, r_w_hold, r_bvalid, r_rvalid;
    logic [ADDR_WD-1:0]         r_awaddr;
    logic [DATA_WD-1:0]         r_wdata, r_rdata;
    logic [1:0]                 r_bresp, r_rresp;

    logic                       w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok, w_rd_ok;
    logic [ADDR_WD-1:0]         w_wr_addr;
    logic [DATA_WD-1:0]         w_wr_data, w_rd_data;

    assign awready   = !r_aw_hold && !r_bvalid;
    assign wready    = !r_w_hold && !r_bvalid;
    assign arready   = !r_rvalid;
    assign w_aw_hs   = awvalid && awready;
    assign w_w_hs    = wvalid && wready;
    assign w_ar_hs   = arvalid && arready;
    // Commit once both halves are present, whether fresh this edge or held.
    assign w_commit  = (w_aw_hs || r_aw_hold) && (w_w_hs || r_w_hold);
    assign w_wr_addr = w_aw_hs ? awaddr : r_awaddr;
    assign w_wr_data = w_w_hs ? wdata : r_wdata;
    assign w_wr_ok   = {1'b0, w_wr_addr} < LP_REG_NUM;
    assign w_rd_ok   = {1'b0, araddr} < LP_REG_NUM;

    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign rvalid  = r_rvalid;
    assign rresp   = r_rresp;
    assign rdata   = r_rdata;
    assign reg_out = r_regs;

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < REG_NUM; i++)
            if (araddr == ADDR_WD'(i)) w_rd_data = r_regs[i*DATA_WD +: DATA_WD];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_regs <= '0;
        end else if (w_commit && w_wr_ok) begin
            for (int i = 0; i < REG_NUM; i++)
                if (w_wr_addr == ADDR_WD'(i)) r_regs[i*DATA_WD +: DATA_WD] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_aw_hold <= 1'b0;
            r_w_hold  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            if (w_aw_hs) r_awaddr <= awaddr;
            if (w_w_hs) r_wdata <= wdata;
            if (w_commit) begin
                r_aw_hold <= 1'b0;
                r_w_hold  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_ok ? 2'b00 : 2'b10;
            end else begin
                if (w_aw_hs) r_aw_hold <= 1'b1;
                if (w_w_hs) r_w_hold <= 1'b1;
                if (r_bvalid && bready) r_bvalid <= 1'b0;
            end
        end
    end

    // Read samples the array before any same-edge write lands.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= 2'b00;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_ok ? w_rd_data : '0;
            r_rresp  <= w_rd_ok ? 2'b00 : 2'b10;
        end else if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// tb_axi_lite_slave_regfile: directed checks of the AXI-lite register file.
// Inputs are driven and outputs sampled just after each falling edge.
module tb_axi_lite_slave_regfile;
    logic         clk = 1'b0;
    logic         rstn;
    logic [7:0]   awaddr, wdata, araddr;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [7:0]   rdata;
    logic [127:0] reg_out;
    logic [7:0]   exp_regs [16];
    int           checks = 0;
    int           failures = 0;

    axi_lite_slave_regfile dut (
        .clk(clk), .rstn(rstn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_out(reg_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_bus();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = exp_regs[i];
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; awaddr = '0; wdata = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        tick(); tick();
        check("rst_reg_out", reg_out, '0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_readys", {awready, wready, arready}, 3'b111);
        rstn = 1'b1;
        tick();
        // same-cycle AW+W
        awaddr = 8'h03; wdata = 8'hA5; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; exp_regs[3] = 8'hA5;
        check("t1_bvalid", bvalid, 1);
        check("t1_bresp", bresp, 2'b00);
        check("t1_reg3", reg_out[31:24], 8'hA5);
        check("t1_readys_busy", {awready, wready}, 2'b00);
        tick();
        check("t1_bclear", bvalid, 0);
        check("t1_readys", {awready, wready}, 2'b11);
        // W first, AW three cycles later
        wdata = 8'h5A; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("t2_wready", wready, 0);
        check("t2_awready", awready, 1);
        tick(); tick();
        check("t2_nocommit", bvalid, 0);
        awaddr = 8'h07; awvalid = 1'b1;
        tick();
        awvalid = 1'b0; exp_regs[7] = 8'h5A;
        check("t2_bvalid", bvalid, 1);
        check("t2_reg_out", reg_out, exp_bus());
        tick();
        // out-of-range write then read
        awaddr = 8'h20; wdata = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t3_bvalid", bvalid, 1);
        check("t3_bresp", bresp, 2'b10);
        check("t3_reg_out", reg_out, exp_bus());
        tick();
        araddr = 8'h20; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("t3_rvalid", rvalid, 1);
        check("t3_rresp", rresp, 2'b10);
        check("t3_rdata", rdata, 8'h00);
        check("t3_arready", arready, 0);
        rready = 1'b1;
        tick();
        check("t3_rclear", rvalid, 0);
        rready = 1'b0;
        // B backpressure
        bready = 1'b0;
        awaddr = 8'h05; wdata = 8'h33; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        exp_regs[5] = 8'h33;
        awaddr = 8'h06; wdata = 8'h44;
        for (int i = 0; i < 4; i++) begin
            check("t4_stall", {bvalid, bresp, awready, wready}, 5'b1_00_00);
            tick();
        end
        check("t4_reg_out", reg_out, exp_bus());
        bready = 1'b1;
        tick();
        check("t4_bclear", bvalid, 0);
        check("t4_reg6_pending", reg_out[55:48], 8'h00);
        check("t4_readys", {awready, wready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; exp_regs[6] = 8'h44;
        check("t4_bvalid2", bvalid, 1);
        check("t4_reg_out2", reg_out, exp_bus());
        tick();
        // read/write collision on register 3
        wdata = 8'h11; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        awaddr = 8'h03; awvalid = 1'b1; araddr = 8'h03; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; arvalid = 1'b0; exp_regs[3] = 8'h11;
        check("t5_rvalid", rvalid, 1);
        check("t5_rdata_old", rdata, 8'hA5);
        check("t5_rresp", rresp, 2'b00);
        check("t5_reg3_new", reg_out[31:24], 8'h11);
        check("t5_bvalid", bvalid, 1);
        rready = 1'b1;
        tick();
        rready = 1'b0; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("t5_rdata_new", rdata, 8'h11);
        // reset mid-flight
        awaddr = 8'h02; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("t6_aw_held", awready, 0);
        check("t6_rvalid_pre", rvalid, 1);
        rstn = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        check("t6_rst_valids", {rvalid, bvalid}, 2'b00);
        check("t6_rst_reg_out", reg_out, '0);
        check("t6_rst_awready", awready, 1);
        tick();
        rstn = 1'b1;
        wdata = 8'h77; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("t6_w_only", bvalid, 0);
        tick(); tick();
        check("t6_no_commit", {bvalid, reg_out[23:16]}, 9'h000);
        awaddr = 8'h02; awvalid = 1'b1;
        tick();
        awvalid = 1'b0; exp_regs[2] = 8'h77;
        check("t6_bvalid", bvalid, 1);
        check("t6_reg_out", reg_out, exp_bus());
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
